// File: rtl/performance_ch_erase_collector_pkg.sv
// Shared widths and FSM state encodings for the channel erase statistics collector.
package performance_ch_erase_collector_pkg;

  localparam int SLV_DATA_WD = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_DIVIDE   = 3'd2,
    ST_UPDATE   = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_t;

endpackage

// File: rtl/perf_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, DIVIDEND_WD cycles after start.
// A zero divisor yields a zero quotient instead of all-ones.
module perf_seq_divider #(
  parameter int DIVIDEND_WD = 32,
  parameter int DIVISOR_WD  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DIVIDEND_WD-1:0] dividend,
  input  logic [DIVISOR_WD-1:0]  divisor,
  output logic                   done,
  output logic [DIVIDEND_WD-1:0] quotient
);

  localparam int CNT_WD = $clog2(DIVIDEND_WD + 1);

  logic [DIVIDEND_WD-1:0] quo_q;
  logic [DIVISOR_WD-1:0]  rem_q;
  logic [DIVISOR_WD-1:0]  dvs_q;
  logic [CNT_WD-1:0]      cnt_q;
  logic [DIVISOR_WD:0]    trial;
  logic                   fits;
  logic [DIVISOR_WD-1:0]  rem_nxt;

  // quo_q starts as the dividend and shifts quotient bits in from the bottom
  assign trial   = {rem_q, quo_q[DIVIDEND_WD-1]};
  assign fits    = (dvs_q != '0) && (trial >= {1'b0, dvs_q});
  assign rem_nxt = fits ? (trial[DIVISOR_WD-1:0] - dvs_q) : trial[DIVISOR_WD-1:0];

  assign done     = (cnt_q == CNT_WD'(1));
  assign quotient = quo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= CNT_WD'(DIVIDEND_WD);
    end else if (cnt_q != '0) begin
      quo_q <= {quo_q[DIVIDEND_WD-2:0], fits};
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - CNT_WD'(1);
    end
  end

endmodule

// File: rtl/performance_ch_erase_collector.sv
// Per-batch erase latency statistics: average cycles per erase, running max, batch count.
// Max tracking is built only when PERF_ERASE_MAX_TRACK_EN is defined.
//
// state       | meaning
// IDLE        | waiting for i_erase_ready
// CAPTURE     | snapshot count and request count into the divider
// DIVIDE      | iterative divide, DATA_WD cycles
// UPDATE      | write avg/max/batch statistics
// ACK         | one-cycle copy-complete pulse
// WAIT_LOW    | hold until i_erase_ready drops
module performance_ch_erase_collector
  import performance_ch_erase_collector_pkg::*;
#(
  parameter int DATA_WD  = SLV_DATA_WD,
  parameter int REQ_WD   = 10,
  parameter int BATCH_WD = 16
) (
  input  logic                i_bus_clk,
  input  logic                i_bus_rst_n,
  input  logic                i_erase_ready,
  input  logic [DATA_WD-1:0]  i_erase_cnt,
  input  logic [REQ_WD-1:0]   i_erase_req_cnt,
  output logic                o_erase_cnt_cp_cmplt,
  input  logic                i_clear,
  output logic [DATA_WD-1:0]  o_erase_avg,
  output logic [DATA_WD-1:0]  o_erase_avg_max,
  output logic [BATCH_WD-1:0] o_batch_cnt,
  output logic                o_busy
);

  state_t             state_q, state_d;
  logic               div_done;
  logic [DATA_WD-1:0] quotient;

  perf_seq_divider #(
    .DIVIDEND_WD (DATA_WD),
    .DIVISOR_WD  (REQ_WD)
  ) u_div (
    .clk      (i_bus_clk),
    .rst_n    (i_bus_rst_n),
    .start    (state_q == ST_CAPTURE),
    .dividend (i_erase_cnt),
    .divisor  (i_erase_req_cnt),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (i_erase_ready) state_d = ST_CAPTURE;
      ST_CAPTURE:  state_d = ST_DIVIDE;
      ST_DIVIDE:   if (div_done) state_d = ST_UPDATE;
      ST_UPDATE:   state_d = ST_ACK;
      ST_ACK:      state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!i_erase_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy               = (state_q != ST_IDLE);
    o_erase_cnt_cp_cmplt = (state_q == ST_ACK);
  end

  // clear has priority over a coincident UPDATE, discarding that batch
  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      o_erase_avg <= '0;
      o_batch_cnt <= '0;
    end else if (i_clear) begin
      o_erase_avg <= '0;
      o_batch_cnt <= '0;
    end else if (state_q == ST_UPDATE) begin
      o_erase_avg <= quotient;
      if (o_batch_cnt != '1) o_batch_cnt <= o_batch_cnt + BATCH_WD'(1);
    end
  end

`ifdef PERF_ERASE_MAX_TRACK_EN
  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n)                                         o_erase_avg_max <= '0;
    else if (i_clear)                                         o_erase_avg_max <= '0;
    else if (state_q == ST_UPDATE && quotient > o_erase_avg_max) o_erase_avg_max <= quotient;
  end
`else
  assign o_erase_avg_max = '0;
`endif

endmodule

// File: tb/tb_performance_ch_erase_collector.sv
// Scoreboard bench for the erase statistics collector with a behavioural reference model.
module tb_performance_ch_erase_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] cnt = '0;
  logic [9:0]  req = '0;
  logic        cp;
  logic [31:0] avg, avg_max;
  logic [15:0] batch;
  logic        busy;

  performance_ch_erase_collector #(
    .DATA_WD (32),
    .REQ_WD  (10),
    .BATCH_WD(16)
  ) dut (
    .i_bus_clk           (clk),
    .i_bus_rst_n         (rst_n),
    .i_erase_ready       (ready),
    .i_erase_cnt         (cnt),
    .i_erase_req_cnt     (req),
    .o_erase_cnt_cp_cmplt(cp),
    .i_clear             (clear),
    .o_erase_avg         (avg),
    .o_erase_avg_max     (avg_max),
    .o_batch_cnt         (batch),
    .o_busy              (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned pcyc;
    logic [31:0] avg;
    logic [31:0] mx;
    logic [15:0] batch;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_avg = '0;
  logic [31:0] m_max = '0;
  logic [15:0] m_batch = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every copy-complete pulse must match the oldest pending batch
  always @(negedge clk) begin
    if (rst_n && cp === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(mon_e.pcyc));
        chk("avg", 64'(avg), 64'(mon_e.avg));
        chk("avg_max", 64'(avg_max), 64'(mon_e.mx));
        chk("batch_cnt", 64'(batch), 64'(mon_e.batch));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic model_batch(input logic [31:0] c_v, input logic [9:0] r_v);
    logic [31:0] e_avg;
    e_avg = (r_v == 0) ? 32'd0 : c_v / {22'd0, r_v};
    m_avg = e_avg;
    if (m_batch != 16'hFFFF) m_batch = m_batch + 16'd1;
`ifdef PERF_ERASE_MAX_TRACK_EN
    if (e_avg > m_max) m_max = e_avg;
`endif
  endtask

  task automatic run_batch(input logic [31:0] c_v, input logic [9:0] r_v,
                           input int hold, input bit clr_update);
    int unsigned c;
    int last;
    wait_idle();
    cnt   = c_v;
    req   = r_v;
    ready = 1'b1;
    c     = cyc;
    if (clr_update) begin
      m_avg = '0; m_max = '0; m_batch = '0;
    end else begin
      model_batch(c_v, r_v);
    end
    q.push_back('{c + 35, m_avg, m_max, m_batch});
    last = (hold > 36) ? hold : 36;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_after_ready", 64'(busy), 64'd1);
      if (k >= 2) begin
        cnt = $urandom;
        req = 10'($urandom);
      end
      if (clr_update) clear = (k == 34);
      if (k == hold) ready = 1'b0;
    end
    clear = 1'b0;
    ready = 1'b0;
  endtask

  task automatic reset_mid_divide();
    int unsigned c;
    wait_idle();
    cnt   = 32'd80000;
    req   = 10'd100;
    ready = 1'b1;
    c     = cyc;
    for (int k = 1; k <= 11; k++) @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    chk("rst_avg", 64'(avg), 64'd0);
    chk("rst_max", 64'(avg_max), 64'd0);
    chk("rst_batch", 64'(batch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cp", 64'(cp), 64'd0);
    m_avg = '0; m_max = '0; m_batch = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_batch", 64'(batch), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int h;
    logic [31:0] rc;
    logic [9:0]  rr;
    repeat (3) @(negedge clk);
    chk("reset_avg", 64'(avg), 64'd0);
    chk("reset_max", 64'(avg_max), 64'd0);
    chk("reset_batch", 64'(batch), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cp", 64'(cp), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_batch(32'd25000, 10'd1000, 40, 1'b0);
    run_batch(32'd30000, 10'd1000, 5, 1'b0);
    run_batch(32'd10000, 10'd1000, 5, 1'b0);
    run_batch(32'd500, 10'd0, 5, 1'b0);
    run_batch(32'd12345, 10'd7, 100, 1'b0);
    run_batch(32'd999, 10'd3, 3, 1'b0);
    run_batch(32'd40000, 10'd100, 5, 1'b1);
    run_batch(32'd70000, 10'd1000, 5, 1'b0);
    reset_mid_divide();
    run_batch(32'd25000, 10'd1000, 5, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rc = $urandom;
      rr = (i % 5 == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      h  = $urandom_range(1, 60);
      run_batch(rc, rr, h, 1'b0);
    end

    wait_idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("idle_clear_avg", 64'(avg), 64'd0);
    chk("idle_clear_max", 64'(avg_max), 64'd0);
    chk("idle_clear_batch", 64'(batch), 64'd0);
    m_avg = '0; m_max = '0; m_batch = '0;
    run_batch(32'd5000, 10'd50, 5, 1'b0);

    wait_idle();
    chk("pending_pulses", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
